bnn_param_loader: RTL
=====================

// Module: bnn_param_loader
// PURPOSE
//   Upstream programmer for the neuron parameter shift chain. Accepts parameter bytes over a valid/ready
//   stream and serialises them MSB-first onto the chain's setup/param_in pair, 1 bit per clk.
//   Drives exactly CHAIN_BITS shift cycles per load, then signals done. Sits between byte I/O and layer chain.
// PARAMETERS
//   NEURONS    8  neurons daisy-chained on one param chain
//   INPUTS     8  weight bits per neuron
//   BIAS_BITS  3  bias bits per neuron
//   CHAIN_BITS (derived, localparam) = NEURONS*(INPUTS+BIAS_BITS); default 88
// PORTS
//   clk        in   1  single clock
//   reset      in   1  synchronous, active-high reset
//   start      in   1  1-cycle request to begin a load; ignored unless IDLE
//   in_data    in   8  parameter byte, bit 7 shifted first
//   in_valid   in   1  in_data valid
//   in_ready   out  1  loader accepts in_data this edge when in_valid&in_ready
//   setup      out  1  chain shift enable (to first neuron setup)
//   param_out  out  1  serial bit (to first neuron param_in)
//   busy       out  1  high in LOAD
//   done       out  1  1-cycle pulse after last chain bit shifted
//   checksum   out  8  XOR of accepted bytes (only with BNN_LOADER_CHECKSUM_EN)
// BEHAVIOUR
//   - Reset: state=IDLE, buf=0, buf_cnt=0, bits_left=0; setup=0, param_out=0, in_ready=0, busy=0,
//     done=0, checksum=0. Reset mid-load aborts at once; setup low on next cycle; chain contents undefined.
//   - FSM: IDLE -start-> LOAD (bits_left=CHAIN_BITS); LOAD -last bit shifted-> DONE; DONE -> IDLE (1 cycle).
//   - setup = (state==LOAD && buf_cnt!=0); param_out = buf[7]. Both from registers, no in_* comb path.
//   - Each cycle with setup=1: buf<<=1, buf_cnt--, bits_left--. Chain samples setup/param_out at same edge.
//   - in_ready = LOAD && bytes_owed!=0 && (buf_cnt==0 || buf_cnt==1); buf_cnt==1 case = prefetch,
//     new byte overwrites buf at the edge consuming the last bit -> gapless 1 bit/clk.
//   - On accept: buf=in_data, buf_cnt=min(8, bits_left after this edge's shift); bytes_owed--.
//   - Total bytes = ceil(CHAIN_BITS/8). Partial final byte: only top (CHAIN_BITS%8) bits used, rest dropped.
//   - Starvation (in_valid=0 with buf_cnt==0): setup=0, chain holds; resumes without loss or duplication.
//   - First bit shifted ends in last neuron's bias MSB; last bit in first neuron's weight LSB.
//   - done asserts the cycle after the final setup=1 cycle (state DONE); busy=0, in_ready=0 there.
//   - start during LOAD/DONE ignored. start and reset same edge: reset wins.
//   - in_valid while not ready: byte held by source, never consumed.
// CONFIGURATION
//   BNN_LOADER_CHECKSUM_EN defined: checksum port present; cleared on start accept, ^=in_data on
//     every accepted byte, stable from done until next start. Undefined: port absent, no register.
// STRUCTURE
//   - Shared package bnn_pkg: CHAIN_BITS/bytes-per-load computation, LOADER_IDLE/LOAD/DONE state codes,
//     BYTE_BITS=8 constant; reused by layer and top-level.
//   - One sub-module: param_byte_serializer (buf, buf_cnt, prefetch load, MSB-first shift); FSM,
//     bits_left/bytes_owed counters and checksum stay in bnn_param_loader.
// TESTING
//   1 NEURONS=1 (11 bits): start, bytes 0xA5,0xE0 always valid -> setup high 11 consecutive cycles,
//     param_out=1,0,1,0,0,1,0,1,1,1,1; weights=0x2F, bias=3'b101; done one cycle later; 2 bytes accepted.
//   2 Default 88 bits, 11 bytes back-to-back -> exactly 88 setup cycles, no gaps, done pulse once, in_ready
//     never high after 11th accept; chain model readback matches.
//   3 Starvation: NEURONS=1, drop in_valid 5 cycles after byte 1 -> setup=0 those cycles, param_out
//     sequence unchanged, total setup cycles still 11.
//   4 Reset at shift cycle 4 of default load -> next cycle setup=0, busy=0, in_ready=0; fresh start then
//     completes full 88-bit load correctly.
//   5 start pulsed while busy and in DONE -> ignored; single done per load; in_valid with in_ready=0
//     in IDLE consumes nothing.
//   6 BNN_LOADER_CHECKSUM_EN, NEURONS=1, bytes 0xA5,0xE0 -> checksum=0x45 at done, held until next start.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared constants, loader state codes and chain-size helpers for the BNN parameter path.
package bnn_pkg;

    localparam int BYTE_BITS = 8;
    localparam int CNT_W     = $clog2(BYTE_BITS + 1);

    typedef enum logic [1:0] {
        LOADER_IDLE = 2'd0,
        LOADER_LOAD = 2'd1,
        LOADER_DONE = 2'd2
    } loader_state_e;

    function automatic int chain_bits(input int neurons, input int inputs, input int bias_bits);
        return neurons * (inputs + bias_bits);
    endfunction

    function automatic int bytes_per_load(input int bits);
        return (bits + BYTE_BITS - 1) / BYTE_BITS;
    endfunction

endpackage

// File: rtl/bnn_param_loader_if.sv
// Byte stream carrying parameter bytes into the loader (valid/ready handshake).
interface bnn_param_loader_if;
    import bnn_pkg::*;

    logic [BYTE_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/bnn_param_byte_serializer.sv
// MSB-first byte shifter; a load at the edge that consumes the last bit replaces the buffer gaplessly.
module param_byte_serializer
    import bnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [BYTE_BITS-1:0] data_i,
    input  logic [CNT_W-1:0]     count_i,
    input  logic                 shift_i,
    output logic                 msb_o,
    output logic [CNT_W-1:0]     count_o
);

    logic [BYTE_BITS-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // A load wins over the shift: the shifted-out bit is the last one of the old byte.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (load_i) begin
            buf_d = data_i;
            cnt_d = count_i;
        end else if (shift_i) begin
            buf_d = {buf_q[BYTE_BITS-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign msb_o   = buf_q[BYTE_BITS-1];
    assign count_o = cnt_q;

endmodule

// File: rtl/bnn_param_loader.sv
// Streams CHAIN_BITS parameter bits MSB-first onto the neuron setup/param chain.
// Optional checksum port enabled by defining BNN_LOADER_CHECKSUM_EN.
module bnn_param_loader
    import bnn_pkg::*;
#(
    parameter int NEURONS   = 8,
    parameter int INPUTS    = 8,
    parameter int BIAS_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    bnn_param_loader_if.slave    in_if,
    output logic                 setup_o,
    output logic                 param_out_o,
    output logic                 busy_o,
    output logic                 done_o
`ifdef BNN_LOADER_CHECKSUM_EN
    ,
    output logic [BYTE_BITS-1:0] checksum_o
`endif
);

    localparam int CHAIN_BITS = chain_bits(NEURONS, INPUTS, BIAS_BITS);
    localparam int NUM_BYTES  = bytes_per_load(CHAIN_BITS);
    localparam int BL_W       = $clog2(CHAIN_BITS + 1);
    localparam int BO_W       = $clog2(NUM_BYTES + 1);

    loader_state_e   state_q;
    logic [BL_W-1:0] bits_left_q;
    logic [BO_W-1:0] bytes_owed_q;
    logic            busy_q;
    logic            done_q;

    logic            shift;
    logic            accept;
    logic [BL_W-1:0] bits_after;
    logic [CNT_W-1:0] load_count;
    logic [CNT_W-1:0] buf_cnt;
    logic            buf_msb;

    assign shift      = (state_q == LOADER_LOAD) && (buf_cnt != '0);
    assign in_if.in_ready = (state_q == LOADER_LOAD) && (bytes_owed_q != '0) && (buf_cnt <= CNT_W'(1));
    assign accept     = in_if.in_valid && in_if.in_ready;
    assign bits_after = bits_left_q - BL_W'(shift);
    // The final byte may carry fewer useful bits than a full byte; the rest are never shifted.
    assign load_count = (bits_after >= BL_W'(BYTE_BITS)) ? CNT_W'(BYTE_BITS) : CNT_W'(bits_after);

    param_byte_serializer u_serializer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .data_i  (in_if.in_data),
        .count_i (load_count),
        .shift_i (shift),
        .msb_o   (buf_msb),
        .count_o (buf_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOADER_IDLE;
            bits_left_q  <= '0;
            bytes_owed_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                LOADER_IDLE: begin
                    if (start_i) begin
                        state_q      <= LOADER_LOAD;
                        bits_left_q  <= BL_W'(CHAIN_BITS);
                        bytes_owed_q <= BO_W'(NUM_BYTES);
                        busy_q       <= 1'b1;
                    end
                end
                LOADER_LOAD: begin
                    if (shift)  bits_left_q  <= bits_left_q - BL_W'(1);
                    if (accept) bytes_owed_q <= bytes_owed_q - BO_W'(1);
                    if (shift && bits_left_q == BL_W'(1)) begin
                        state_q <= LOADER_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                LOADER_DONE: state_q <= LOADER_IDLE;
                default:     state_q <= LOADER_IDLE;
            endcase
        end
    end

    assign setup_o     = shift;
    assign param_out_o = buf_msb;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

`ifdef BNN_LOADER_CHECKSUM_EN
    logic [BYTE_BITS-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (state_q == LOADER_IDLE && start_i) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q ^ in_if.in_data;
        end
    end

    assign checksum_o = checksum_q;
`endif

endmodule
